// File: rtl/inst_prefetch_queue_if.sv
// rtl/inst_prefetch_queue_if.sv - memory-port and decode-side signals of the instruction prefetch queue
interface inst_prefetch_queue_if;
    logic [31:0] mem_fetch_addr;
    logic        mem_fetch_addr_en;
    logic        mem_fetch_ready;
    logic [31:0] mem_inst_in;
    logic        mem_inst_valid;
    logic        mem_inst_access_fault;
    logic        override_pc;
    logic [31:0] override_pc_addr;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        valid;
    logic [5:0]  exception_num;
    logic        exception_valid;
    logic        stall;

    modport master (
        output mem_fetch_addr, mem_fetch_addr_en, inst, inst_pc, valid, exception_num, exception_valid,
        input  mem_fetch_ready, mem_inst_in, mem_inst_valid, mem_inst_access_fault,
               override_pc, override_pc_addr, stall
    );

    modport slave (
        input  mem_fetch_addr, mem_fetch_addr_en, inst, inst_pc, valid, exception_num, exception_valid,
        output mem_fetch_ready, mem_inst_in, mem_inst_valid, mem_inst_access_fault,
               override_pc, override_pc_addr, stall
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - in-order instruction prefetch queue with redirect and exception entries
// Optional FETCH_BYPASS_EN presents a response to an empty queue in the same cycle.
module inst_prefetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] IDLE_INST = 32'h000c_0de0;
    localparam logic [31:0] EXC_INST  = 32'h001c_0de0;

    logic [31:0]   r_q_inst  [QUEUE_DEPTH];
    logic [31:0]   r_q_pc    [QUEUE_DEPTH];
    logic          r_q_exc   [QUEUE_DEPTH];
    logic          r_q_fault [QUEUE_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;
    logic [31:0]   r_fetch_pc;
    logic          r_halted;

    logic          w_credit;
    logic          w_accept;
    logic          w_resp_live;
    logic          w_misalign;
    logic          w_bypass;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_push_inst;
    logic [31:0]   w_push_pc;
    logic          w_push_exc;
    logic          w_push_fault;
    logic [31:0]   w_resp_pc;
    logic [OW-1:0] w_outstanding_next;

    // Credit counts in-flight requests too, so a returning response always finds a free slot.
    assign w_credit = (32'(r_count) + 32'(r_outstanding)) < 32'(QUEUE_DEPTH);

    assign bus.mem_fetch_addr    = r_fetch_pc;
    assign bus.mem_fetch_addr_en = ~reset & ~bus.override_pc & ~r_halted & (r_fetch_pc[1:0] == 2'b00)
                                 & w_credit & (32'(r_outstanding) < 32'(MAX_OUTSTANDING));

    assign w_accept           = bus.mem_fetch_addr_en & bus.mem_fetch_ready;
    assign w_outstanding_next = r_outstanding + OW'(w_accept) - OW'(bus.mem_inst_valid);

    // Live requests were issued sequentially up to fetch_pc, so the oldest sits outstanding words back.
    assign w_resp_pc   = r_fetch_pc - (32'(r_outstanding) << 2);
    assign w_resp_live = bus.mem_inst_valid & (r_discard == '0) & ~r_halted & ~bus.override_pc;
    assign w_misalign  = (r_fetch_pc[1:0] != 2'b00) & ~r_halted & w_credit & ~bus.override_pc;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_resp_live & (r_count == '0) & ~bus.stall;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_push       = 1'b0;
        w_push_pc    = w_resp_pc;
        w_push_inst  = bus.mem_inst_in;
        w_push_exc   = 1'b0;
        w_push_fault = 1'b0;
        if (w_resp_live) begin
            w_push       = ~w_bypass;
            w_push_exc   = bus.mem_inst_access_fault;
            w_push_fault = bus.mem_inst_access_fault;
            if (bus.mem_inst_access_fault) begin
                w_push_inst = EXC_INST;
            end
        end else if (w_misalign) begin
            w_push      = 1'b1;
            w_push_pc   = r_fetch_pc;
            w_push_inst = EXC_INST;
            w_push_exc  = 1'b1;
        end
    end

    always_comb begin
        bus.valid           = 1'b0;
        bus.inst            = IDLE_INST;
        bus.inst_pc         = '0;
        bus.exception_valid = 1'b0;
        bus.exception_num   = '0;
        if (~reset & ~bus.override_pc) begin
            if (r_count != '0) begin
                bus.valid           = 1'b1;
                bus.inst            = r_q_inst[r_rd_ptr];
                bus.inst_pc         = r_q_pc[r_rd_ptr];
                bus.exception_valid = r_q_exc[r_rd_ptr];
                bus.exception_num   = {5'b0, r_q_fault[r_rd_ptr]};
            end else if (w_bypass) begin
                bus.valid           = 1'b1;
                bus.inst            = w_push_inst;
                bus.inst_pc         = w_push_pc;
                bus.exception_valid = w_push_exc;
                bus.exception_num   = {5'b0, w_push_fault};
            end
        end
    end

    assign w_pop = bus.valid & ~bus.stall & (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (bus.override_pc) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_fetch_pc <= bus.override_pc_addr;
                r_halted   <= 1'b0;
                r_discard  <= w_outstanding_next;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (bus.mem_inst_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - OW'(1);
                end
                if (w_push_exc) begin
                    r_halted <= 1'b1;
                end
                if (w_push) begin
                    r_q_inst[r_wr_ptr]  <= w_push_inst;
                    r_q_pc[r_wr_ptr]    <= w_push_pc;
                    r_q_exc[r_wr_ptr]   <= w_push_exc;
                    r_q_fault[r_wr_ptr] <= w_push_fault;
                    r_wr_ptr            <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule
